// File: rtl/cdc_fifo_read_packer.sv
// Read-domain packer downstream of cdc_fifo: pops narrow FIFO words into a wide
// beat and presents it on a registered valid/ready output; flush closes a partial beat.
module cdc_fifo_read_packer #(
  parameter int DATA_WIDTH     = 4,
  parameter int WORDS_PER_BEAT = 2,
  parameter int COUNT_WIDTH    = 8
) (
  input  logic                                 read_clock,
  input  logic                                 read_reset,
  input  logic                                 fifo_empty,
  input  logic [DATA_WIDTH-1:0]                fifo_read_data,
  output logic                                 fifo_read_increment,
  input  logic                                 flush,
  output logic [DATA_WIDTH*WORDS_PER_BEAT-1:0] out_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 out_partial,
  output logic [COUNT_WIDTH-1:0]               beat_count
);
  localparam int AW = $clog2(WORDS_PER_BEAT + 1);
  localparam logic [AW-1:0] FULL = AW'(WORDS_PER_BEAT);

  logic [WORDS_PER_BEAT-1:0][DATA_WIDTH-1:0] asm_q;
  logic [AW-1:0] asm_count;
  logic          partial_q;
  logic          flush_take, pop, xfer, accept;

  // Pop path deliberately excludes out_ready; the assembly register is the only buffer.
  assign flush_take = flush && (asm_count != '0) && (asm_count < FULL);
  assign pop        = !read_reset && !fifo_empty && (asm_count < FULL) && !flush_take;
  assign xfer       = (asm_count == FULL) && (!out_valid || out_ready);
  assign accept     = out_valid && out_ready;
  assign fifo_read_increment = pop;

  always_ff @(posedge read_clock) begin
    if (read_reset) begin
      asm_q       <= '0;
      asm_count   <= '0;
      partial_q   <= 1'b0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_partial <= 1'b0;
      beat_count  <= '0;
    end else begin
      if (accept) beat_count <= beat_count + COUNT_WIDTH'(1);
      if (xfer) begin
        out_data    <= asm_q;
        out_partial <= partial_q;
        out_valid   <= 1'b1;
        asm_q       <= '0;
        asm_count   <= '0;
        partial_q   <= 1'b0;
      end else begin
        if (accept) out_valid <= 1'b0;
        if (pop) begin
          for (int i = 0; i < WORDS_PER_BEAT; i++)
            if (asm_count == AW'(i)) asm_q[i] <= fifo_read_data;
          asm_count <= asm_count + AW'(1);
        end
        // Unfilled slots are already zero, so forcing full yields a zero-padded beat.
        if (flush_take) begin
          asm_count <= FULL;
          partial_q <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_cdc_fifo_read_packer.sv
// Directed bench for cdc_fifo_read_packer with a queue-modelled FIFO and a
// word-order scoreboard for the randomized ready/empty stress run.
module tb_cdc_fifo_read_packer;
  logic       read_clock = 1'b0;
  logic       read_reset, fifo_empty, fifo_read_increment, flush;
  logic [3:0] fifo_read_data;
  logic [7:0] out_data;
  logic       out_valid, out_ready, out_partial;
  logic [7:0] beat_count;

  cdc_fifo_read_packer #(.DATA_WIDTH(4), .WORDS_PER_BEAT(2), .COUNT_WIDTH(8)) dut (
    .read_clock(read_clock), .read_reset(read_reset), .fifo_empty(fifo_empty),
    .fifo_read_data(fifo_read_data), .fifo_read_increment(fifo_read_increment),
    .flush(flush), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_partial(out_partial), .beat_count(beat_count)
  );

  always #5 read_clock = ~read_clock;

  logic [3:0] fifo_q[$];
  logic [3:0] sent[$];
  int   n_checks = 0, n_err = 0, pops = 0, beats = 0;
  logic pop_seen, acc_seen, hold_empty = 1'b0, sb_on = 1'b0;
  logic [8:0] acc_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic refresh();
    fifo_empty     = (fifo_q.size() == 0) || hold_empty;
    fifo_read_data = (fifo_q.size() != 0) ? fifo_q[0] : 4'h0;
  endtask

  task automatic push(input logic [3:0] w);
    fifo_q.push_back(w);
    refresh();
  endtask

  // Samples the pop/accept handshakes just before the edge, then models the FIFO head advance.
  task automatic tick();
    logic [3:0] w0, w1, tmp;
    #1;
    pop_seen = fifo_read_increment;
    acc_seen = out_valid && out_ready;
    acc_data = {out_partial, out_data};
    @(posedge read_clock); #1;
    if (pop_seen) begin
      tmp = fifo_q.pop_front();
      pops++;
    end
    if (sb_on && acc_seen) begin
      beats++;
      if (sent.size() >= 2) begin
        w0 = sent.pop_front();
        w1 = sent.pop_front();
        check("sb_beat", 32'(acc_data), {23'd0, 1'b0, w1, w0});
      end else check("sb_extra_beat", 32'(sent.size()), 32'd2);
    end
    if (sb_on) begin
      out_ready  = ($urandom_range(0, 3) != 0);
      hold_empty = ($urandom_range(0, 3) == 0);
    end
    refresh();
  endtask

  initial begin
    int p0;
    logic [3:0] w;
    read_reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    refresh();

    // 1: reset, then a simple two-word beat
    push(4'h3); push(4'hA);
    tick(); tick();
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_partial", 32'(out_partial), 0);
    check("rst_count", 32'(beat_count), 0);
    check("rst_no_pop", 32'(fifo_read_increment), 0);
    read_reset = 1'b0; out_ready = 1'b1;
    tick();
    check("t1_pop1", pops, 1);
    tick();
    check("t1_pop2", pops, 2);
    tick();
    check("t1_valid", 32'(out_valid), 1);
    check("t1_data", 32'(out_data), 32'hA3);
    check("t1_partial", 32'(out_partial), 0);
    check("t1_pops_total", pops, 2);
    tick();
    check("t1_count", 32'(beat_count), 1);
    check("t1_valid_fall", 32'(out_valid), 0);

    // 2: backpressure
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) push(4'(i));
    p0 = pops;
    for (int i = 0; i < 3; i++) tick();
    check("t2_first", 32'(out_data), 32'h21);
    for (int i = 0; i < 7; i++) tick();
    check("t2_held_data", 32'(out_data), 32'h21);
    check("t2_held_valid", 32'(out_valid), 1);
    check("t2_pops", pops - p0, 4);
    out_ready = 1'b1;
    tick();
    check("t2_second", 32'(out_data), 32'h43);
    check("t2_second_valid", 32'(out_valid), 1);
    tick(); tick(); tick();
    check("t2_third", 32'(out_data), 32'h65);
    tick();
    check("t2_count", 32'(beat_count), 4);
    check("t2_idle", 32'(out_valid), 0);

    // 3: flush of a single word, then flush with empty assembly
    push(4'h7);
    tick();
    tick();
    check("t3_one_pop", pops - p0, 7);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    check("t3_data", 32'(out_data), 32'h07);
    check("t3_partial", 32'(out_partial), 1);
    check("t3_valid", 32'(out_valid), 1);
    tick();
    check("t3_count", 32'(beat_count), 5);
    flush = 1'b1;
    tick(); tick();
    flush = 1'b0;
    tick();
    check("t3_empty_flush", 32'(out_valid), 0);
    check("t3_empty_count", 32'(beat_count), 5);

    // 4: flush wins over a non-empty FIFO
    push(4'h8);
    tick();
    push(4'h9); push(4'hB);
    flush = 1'b1;
    tick();
    check("t4_pop_suppressed", 32'(pop_seen), 0);
    flush = 1'b0;
    tick();
    check("t4_partial_data", 32'(out_data), 32'h08);
    check("t4_partial_flag", 32'(out_partial), 1);
    tick(); tick(); tick();
    check("t4_next_data", 32'(out_data), 32'hB9);
    check("t4_next_partial", 32'(out_partial), 0);
    tick();
    check("t4_count", 32'(beat_count), 7);

    // 5: reset with a beat pending and a half-assembled one
    out_ready = 1'b0;
    push(4'hC); push(4'hD); push(4'hE); push(4'hF);
    tick(); tick(); tick(); tick();
    check("t5_pending", 32'(out_valid), 1);
    read_reset = 1'b1;
    tick();
    check("t5_valid", 32'(out_valid), 0);
    check("t5_data", 32'(out_data), 0);
    check("t5_partial", 32'(out_partial), 0);
    check("t5_count", 32'(beat_count), 0);
    check("t5_no_pop", 32'(fifo_read_increment), 0);
    tick();
    check("t5_no_pop_held", 32'(pop_seen), 0);
    check("t5_fifo_kept", fifo_q.size(), 1);
    read_reset = 1'b0;

    // 6: 257 beats under random ready/empty, scoreboarded, counter wrap
    sent = fifo_q;
    for (int i = 0; i < 513; i++) begin
      w = 4'($urandom_range(0, 15));
      sent.push_back(w);
      fifo_q.push_back(w);
    end
    refresh();
    sb_on = 1'b1;
    for (int c = 0; c < 8000 && beats < 257; c++) tick();
    sb_on = 1'b0;
    check("t6_beats", beats, 257);
    check("t6_wrap", 32'(beat_count), 1);
    check("t6_drained", sent.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
